// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   dividend_i;
  logic [WIDTH-1:0]   divisor_i;
  logic               annul_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: finish in one edge when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   dvd_shift;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH-1:0]   partial;
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] result;

  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic               early;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [WIDTH-1:0]   partial_step;
  logic [WIDTH-1:0]   quot_mag;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last_step;

  // Magnitudes are unsigned WIDTH-bit, so the most negative value maps to 2^(WIDTH-1) exactly.
  assign dvd_abs = (bus.signed_i && bus.dividend_i[WIDTH-1]) ? -bus.dividend_i : bus.dividend_i;
  assign dvs_abs = (bus.signed_i && bus.divisor_i[WIDTH-1])  ? -bus.divisor_i  : bus.divisor_i;

`ifdef DIV_EARLY_OUT_EN
  assign early = (dvd_abs < dvs_abs);
`else
  assign early = 1'b0;
`endif

  // One extra bit on the trial difference keeps large unsigned divisors from overflowing.
  assign trial        = {partial, dvd_shift[WIDTH-1]} - {1'b0, dvs_mag};
  assign qbit         = ~trial[WIDTH];
  assign partial_step = qbit ? trial[WIDTH-1:0] : {partial[WIDTH-2:0], dvd_shift[WIDTH-1]};
  assign quot_mag     = {dvd_shift[WIDTH-2:0], qbit};
  assign quot_fix     = neg_q ? -quot_mag : quot_mag;
  assign rem_fix      = neg_r ? -partial_step : partial_step;
  assign last_step    = (counter == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.annul_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.divisor_i == '0) state_next = DIVZERO;
            else if (early)          state_next = END;
            else                     state_next = ON;
          end
        end
        DIVZERO: state_next = END;
        ON:      if (last_step) state_next = END;
        END:     if (!bus.start_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter   <= '0;
      dvd_shift <= '0;
      dvs_mag   <= '0;
      partial   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
    end else if (bus.annul_i) begin
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            dvd_shift <= dvd_abs;
            dvs_mag   <= dvs_abs;
            partial   <= '0;
            counter   <= '0;
            neg_q     <= bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
            neg_r     <= bus.signed_i & bus.dividend_i[WIDTH-1];
            if (bus.divisor_i != '0 && early)
              result <= {bus.dividend_i, {WIDTH{1'b0}}};
          end
        end
        DIVZERO: result <= '0;
        ON: begin
          partial   <= partial_step;
          dvd_shift <= quot_mag;
          if (last_step) begin
            counter <= '0;
            result  <= {rem_fix, quot_fix};
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (state == DIVZERO) || (state == ON);
  assign bus.ready_o  = (state == END);
  assign bus.result_o = result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus queues expected results, a monitor checks them on ready_o.
module tb_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [63:0] result;
    int          latency;
    int          stamp;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  div_unit_if #(.WIDTH(W)) bus();

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference: plain integer division on 64-bit values, truncating toward zero.
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb_ = longint'({32'd0, b});
    end
    q = sa / sb_;
    r = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int refLatency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (b == 32'd0) return 2;
    ma = (sgn && a[31]) ? -longint'($signed(a)) : longint'({32'd0, a});
    mb = (sgn && b[31]) ? -longint'($signed(b)) : longint'({32'd0, b});
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  // Monitor: every rising ready_o must match the oldest queued expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (bus.ready_o && !prev) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_ready", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("result", bus.result_o, e.result);
            checkOutput("latency", 64'(cyc - e.stamp + 1), 64'(e.latency));
          end
        end
        prev = bus.ready_o;
      end
    end
  end

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    e.result  = refDiv(sgn, a, b);
    e.latency = refLatency(sgn, a, b);
    e.stamp   = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    checkOutput("busy_after_start", 64'(bus.busy_o), 64'(e.latency != 1));
    bus.dividend_i = $urandom;
    bus.divisor_i  = $urandom;
    n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) begin
      checkOutput("ready_timeout", 64'd0, 64'd1);
      return;
    end
    @(negedge clk);
    checkOutput("hold_ready", 64'(bus.ready_o), 64'd1);
    checkOutput("hold_result", bus.result_o, e.result);
    bus.start_i = 1'b0;
    @(negedge clk);
    checkOutput("ready_drop", 64'(bus.ready_o), 64'd0);
  endtask

  task automatic applyAnnul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] saved;
    saved = bus.result_o;
    @(negedge clk);
    bus.signed_i   = 1'b0;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    repeat (11) @(negedge clk);
    checkOutput("busy_before_annul", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    checkOutput("annul_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("annul_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("annul_result", bus.result_o, saved);
    repeat (40) @(negedge clk);
    checkOutput("annul_stays_idle", 64'(bus.ready_o), 64'd0);
  endtask

  task automatic applyMidReset();
    exp_t e;
    @(negedge clk);
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    bus.start_i    = 1'b1;
    e.result  = refDiv(1'b0, 32'd1000, 32'd3);
    e.latency = 33;
    e.stamp   = cyc + 1;
    sb.push_back(e);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("async_rst_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("async_rst_result", bus.result_o, 64'd0);
    sb.delete();
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          n;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.annul_i    = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("reset_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset_result", bus.result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, 32'd100, 32'd7);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'h1234_5678, 32'd0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd0);
    applyAnnul(32'hDEAD_BEEF, 32'd13);
    applyStimulus(1'b0, 32'd9, 32'd3);
    applyStimulus(1'b0, 32'd3, 32'd5);
    applyStimulus(1'b1, 32'hFFFF_FFFD, 32'd5);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'h8000_0000, 32'd1);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin b = $urandom; a = 32'($urandom_range(0, 100)); end
        default: b = $urandom;
      endcase
      applyStimulus(s, a, b);
    end

    applyMidReset();
    applyStimulus(1'b0, 32'd50, 32'd8);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
